whack_a_mole_multi: RTL

//  Parametrised N-hole whack-a-mole game core with built-in per-button debouncing.

---
 rtl/whack_a_mole_multi.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/whack_a_mole_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | whack_a_mole_multi                                                         |
// | N-hole whack-a-mole core: per-button debounce, LFSR hole pick, game FSM.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module whack_a_mole_multi #(
  parameter int N_HOLES         = 4,
  parameter int DEB_CYCLES      = 16,
  parameter int GAP_TICKS       = 200,
  parameter int MOLE_TICKS_INIT = 1000,
  parameter int MOLE_TICKS_MIN  = 250,
  parameter int SPEEDUP_STEP    = 50,
  parameter int SCORE_W         = 7,
  parameter int LIVES_W         = 2,
  parameter int LIVES_INIT      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_HOLES-1:0] buttons,
  input  logic               start,
  output logic [N_HOLES-1:0] moles,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         state,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  localparam int c_hole_w   = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
  localparam int c_deb_w    = $clog2(DEB_CYCLES + 1);
  localparam int c_mt_w     = $clog2(MOLE_TICKS_INIT + 1);
  localparam int c_tick_max = (GAP_TICKS > MOLE_TICKS_INIT) ? GAP_TICKS : MOLE_TICKS_INIT;
  localparam int c_tick_w   = $clog2(c_tick_max + 1);
  localparam logic [15:0]        c_lfsr_seed  = 16'hACE1;
  localparam logic [LIVES_W-1:0] c_lives_init = LIVES_W'(LIVES_INIT);
  localparam logic [LIVES_W-1:0] c_lives_one  = LIVES_W'(1);
  localparam logic [c_mt_w-1:0]  c_mt_init    = c_mt_w'(MOLE_TICKS_INIT);
  localparam logic [c_mt_w-1:0]  c_mt_min     = c_mt_w'(MOLE_TICKS_MIN);
  localparam logic [N_HOLES-1:0] c_one_hot0   = {{(N_HOLES-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SHOW = 3'd1,
    ST_GAP  = 3'd2,
    ST_END  = 3'd3
  } state_t;

  // ---------------- debounce ----------------
  logic [N_HOLES-1:0] r_clean;
  logic [N_HOLES-1:0] r_clean_q;
  logic [N_HOLES-1:0] r_press;
  logic [c_deb_w-1:0] r_deb_cnt [N_HOLES];

  // A press pulse is taken from the registered clean level, giving DEB_CYCLES+1 latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clean   <= '0;
      r_clean_q <= '0;
      r_press   <= '0;
      for (int i = 0; i < N_HOLES; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_clean_q <= r_clean;
      r_press   <= r_clean & ~r_clean_q;
      for (int i = 0; i < N_HOLES; i++) begin
        if (buttons[i] == r_clean[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (32'(r_deb_cnt[i]) == DEB_CYCLES - 1) begin
          r_clean[i]   <= buttons[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------- LFSR ----------------
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= c_lfsr_seed;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // ---------------- game datapath ----------------
  state_t              r_state;
  logic [N_HOLES-1:0]  r_moles;
  logic [SCORE_W-1:0]  r_score;
  logic [LIVES_W-1:0]  r_lives;
  logic                r_hit;
  logic                r_miss;
  logic [c_mt_w-1:0]   r_mole_ticks;
  logic [c_tick_w-1:0] r_tick;
  logic [c_hole_w-1:0] r_hole;

  logic [c_hole_w-1:0] w_hole_pick;
  logic [c_hole_w-1:0] w_hole_next;
  logic [N_HOLES-1:0]  w_next_mask;
  logic [N_HOLES-1:0]  w_mole_mask;
  logic                w_right;
  logic                w_wrong;
  logic                w_gap_done;
  logic                w_timeout;
  logic [c_mt_w-1:0]   w_mt_next;

  assign w_hole_pick = c_hole_w'(r_lfsr % 16'(N_HOLES));

  always_comb begin
    w_hole_next = w_hole_pick;
    if (w_hole_pick == r_hole)
      w_hole_next = (32'(w_hole_pick) == N_HOLES - 1) ? '0 : w_hole_pick + 1'b1;
  end

  assign w_next_mask = c_one_hot0 << w_hole_next;
  assign w_mole_mask = c_one_hot0 << r_hole;
  assign w_right     = |(r_press & w_mole_mask);
  assign w_wrong     = |(r_press & ~w_mole_mask);
  assign w_gap_done  = (32'(r_tick) == GAP_TICKS - 1);
  assign w_timeout   = (32'(r_tick) == 32'(r_mole_ticks) - 32'd1);

  // Compare in 32 bits so the reduction can never wrap below the floor.
  always_comb begin
    if (32'(r_mole_ticks) >= MOLE_TICKS_MIN + SPEEDUP_STEP)
      w_mt_next = c_mt_w'(32'(r_mole_ticks) - SPEEDUP_STEP);
    else
      w_mt_next = c_mt_min;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_moles      <= '0;
      r_score      <= '0;
      r_lives      <= '0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_mole_ticks <= c_mt_init;
      r_tick       <= '0;
      r_hole       <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        ST_IDLE, ST_END: begin
          r_moles <= '0;
          if (start) begin
            r_score      <= '0;
            r_lives      <= c_lives_init;
            r_mole_ticks <= c_mt_init;
            r_tick       <= '0;
            r_state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_gap_done) begin
            r_tick  <= '0;
            r_hole  <= w_hole_next;
            r_moles <= w_next_mask;
            r_state <= ST_SHOW;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        ST_SHOW: begin
          // A wrong hole outranks a simultaneous correct one; a press beats the timeout.
          if (w_wrong || (!w_right && w_timeout)) begin
            r_miss  <= 1'b1;
            r_lives <= r_lives - 1'b1;
            r_moles <= '0;
            r_tick  <= '0;
            r_state <= (r_lives == c_lives_one) ? ST_END : ST_GAP;
          end else if (w_right) begin
            r_hit        <= 1'b1;
            r_score      <= (&r_score) ? r_score : r_score + 1'b1;
            r_mole_ticks <= w_mt_next;
            r_moles      <= '0;
            r_tick       <= '0;
            r_state      <= ST_GAP;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: begin
          r_moles <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign moles      = r_moles;
  assign score      = r_score;
  assign lives      = r_lives;
  assign state      = r_state;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;

endmodule
`default_nettype wire
